// File: rtl/sha_compress_pkg.sv
// SHA-256 compression shared definitions.
// Holds the round constant table, the initial hash value, the FSM state
// encodings and the FIPS 180-4 logical functions used by the datapath.
package sha_compress_pkg;

   // Eight 32-bit words, index 0 = a (or H0), index 7 = h (or H7).
   // Index 0 is the most significant word when the vector is viewed flat.
   typedef logic [0:7][31:0] words_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ROUND  = 2'b01,
      ST_UPDATE = 2'b10,
      ST_DONE   = 2'b11
   } state_t;

   localparam words_t IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [0:63][31:0] K_TAB = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] big_sigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] big_sigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   // Message-schedule functions; the expander lives outside this block
   // but shares these definitions.
   function automatic logic [31:0] small_sigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] small_sigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, y, z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, y, z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/sha_round.sv
// Combinational single SHA-256 round.
//   i_s : working variables a..h before the round
//   i_k : round constant K_t
//   i_w : schedule word W_t
//   o_s : working variables after the round
module sha_round
   import sha_compress_pkg::*;
(
   input  words_t      i_s,
   input  logic [31:0] i_k,
   input  logic [31:0] i_w,
   output words_t      o_s
);

   logic [31:0] t1;
   logic [31:0] t2;

   always_comb begin
      t1 = i_s[7] + big_sigma1(i_s[4]) + ch(i_s[4], i_s[5], i_s[6]) + i_k + i_w;
      t2 = big_sigma0(i_s[0]) + maj(i_s[0], i_s[1], i_s[2]);
      o_s[0] = t1 + t2;
      o_s[1] = i_s[0];
      o_s[2] = i_s[1];
      o_s[3] = i_s[2];
      o_s[4] = i_s[3] + t1;
      o_s[5] = i_s[4];
      o_s[6] = i_s[5];
      o_s[7] = i_s[6];
   end

endmodule

// File: rtl/sha_compress.sv
// SHA-256 block compression engine, one round per accepted schedule word.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start_in       : opens a new block (IDLE only); i_first selects IV load
//   i_w_valid/i_w/i_round : schedule word stream from the expander
//   o_hash         : current H0..H7 (H0 in the top word)
//   o_done         : one-cycle pulse after the feed-forward update
//   o_busy         : block in progress (ROUND/UPDATE)
//   o_error        : sticky, round index did not match the internal counter
//   o_FSM_state    : current state encoding
// DATA_WIDTH is fixed at 32 by the algorithm.
module sha_compress
   import sha_compress_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_in,
   input  logic                  i_first,
   input  logic                  i_w_valid,
   input  logic [DATA_WIDTH-1:0] i_w,
   input  logic [5:0]            i_round,
   output logic [255:0]          o_hash,
   output logic                  o_done,
   output logic                  o_busy,
   output logic                  o_error,
   output logic [1:0]            o_FSM_state
);

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   words_t      work_q, work_d;
   words_t      h_q, h_d;
   logic        err_q, err_d;
   words_t      round_out;

   sha_round u_round (
      .i_s (work_q),
      .i_k (K_TAB[cnt_q]),
      .i_w (i_w),
      .o_s (round_out)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      h_d     = h_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start_in) begin
               h_d     = i_first ? IV : h_q;
               work_d  = h_d;
               cnt_d   = 6'd0;
               err_d   = 1'b0;
               state_d = ST_ROUND;
            end
         end
         ST_ROUND: begin
            // A mismatched index is flagged but the word is still consumed,
            // so the block always completes in 64 accepted words.
            if (i_w_valid) begin
               if (i_round != cnt_q) err_d = 1'b1;
               work_d = round_out;
               cnt_d  = cnt_q + 6'd1;
               if (cnt_q == 6'd63) state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + work_q[i];
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 6'd0;
         work_q  <= '0;
         h_q     <= IV;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         h_q     <= h_d;
         err_q   <= err_d;
      end
   end

   assign o_hash      = h_q;
   assign o_done      = (state_q == ST_DONE);
   assign o_busy      = (state_q == ST_ROUND) || (state_q == ST_UPDATE);
   assign o_error     = err_q;
   assign o_FSM_state = state_q;

endmodule
